// File: rtl/io_timer.sv
// io_timer: DMG-style DIV/TIMA/TMA/TAC timer block on a byte-wide CPU bus.
// DIV exposes the upper byte of a free-running 16-bit counter. TIMA counts
// falling edges of (TAC enable AND selected counter tap). Because the edge
// detector looks at the post-write tap, a DIV write or TAC change that drops
// the tap also produces a TIMA increment. TIMA overflow reloads from TMA and
// raises a one-cycle interrupt pulse.
module io_timer #(
    parameter logic [15:0] P_BASE = 16'hFF04
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iWe,
    output logic [7:0]  oData,
    output logic        oSelected,
    output logic        oTimerIrq
);

    // Pick the divider bit that feeds the TIMA edge detector for a TAC rate code.
    function automatic logic tap_bit(input logic [15:0] cnt, input logic [1:0] rate);
        logic bit_v;
        case (rate)
            2'b00:   bit_v = cnt[9];
            2'b01:   bit_v = cnt[3];
            2'b10:   bit_v = cnt[5];
            2'b11:   bit_v = cnt[7];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_q, tick_d;
    logic        irq_q, irq_d;

    logic [15:0] offset_s;
    logic        sel_s;
    logic        wr_div_s, wr_tima_s, wr_tma_s, wr_tac_s;
    logic        fall_s;

    // Address decode; offset arithmetic keeps the window correct even if it wraps.
    always_comb begin
        offset_s  = iAddr - P_BASE;
        sel_s     = (offset_s[15:2] == 14'd0);
        wr_div_s  = iWe && sel_s && (offset_s[1:0] == 2'd0);
        wr_tima_s = iWe && sel_s && (offset_s[1:0] == 2'd1);
        wr_tma_s  = iWe && sel_s && (offset_s[1:0] == 2'd2);
        wr_tac_s  = iWe && sel_s && (offset_s[1:0] == 2'd3);
    end

    // Next-state for divider, control registers, tick edge detector and TIMA.
    always_comb begin
        if (wr_div_s) begin
            div_cnt_d = 16'h0000;
        end else begin
            div_cnt_d = div_cnt_q + 16'h0001;
        end

        if (wr_tac_s) begin
            tac_d = iData[2:0];
        end else begin
            tac_d = tac_q;
        end

        if (wr_tma_s) begin
            tma_d = iData;
        end else begin
            tma_d = tma_q;
        end

        // Tick uses the post-write divider and TAC so write-induced drops count.
        tick_d = tac_d[2] & tap_bit(div_cnt_d, tac_d[1:0]);
        fall_s = tick_q & ~tick_d;

        irq_d  = 1'b0;
        if (wr_tima_s) begin
            tima_d = iData;
        end else if (fall_s) begin
            if (tima_q == 8'hFF) begin
                // Reload picks up a TMA value written in this same cycle.
                tima_d = tma_d;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_q + 8'h01;
            end
        end else begin
            tima_d = tima_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            div_cnt_q <= 16'h0000;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
        end
    end

    // Combinational read mux; no register changes on read.
    always_comb begin
        oSelected = sel_s;
        if (sel_s) begin
            case (offset_s[1:0])
                2'd0:    oData = div_cnt_q[15:8];
                2'd1:    oData = tima_q;
                2'd2:    oData = tma_q;
                2'd3:    oData = {5'b11111, tac_q};
                default: oData = 8'h00;
            endcase
        end else begin
            oData = 8'h00;
        end
    end

    assign oTimerIrq = irq_q;

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 SHALL have parameter P_BASE, default 16'hFF04, meaning the bus address of DIV; TIMA, TMA and TAC are at P_BASE+1, P_BASE+2 and P_BASE+3.
REQ-002 SHALL have port iClock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port iReset, input, 1, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port iAddr, input, 16, the CPU bus address.
REQ-005 SHALL have port iData, input, 8, the CPU write data.
REQ-006 SHALL have port iWe, input, 1, the CPU write strobe; it is valid for one cycle per write.
REQ-007 SHALL have port oData, output, 8, the combinational read data for iAddr.
REQ-008 SHALL have port oSelected, output, 1, high when iAddr is in P_BASE..P_BASE+3.
REQ-009 SHALL have port oTimerIrq, output, 1, the timer interrupt request; it is a registered one-cycle pulse.

Function
REQ-010 SHALL keep a 16-bit internal counter rDivCnt that increments by 1 every clock and wraps from FFFF to 0000; DIV reads rDivCnt[15:8].
REQ-011 SHALL reset rDivCnt to 0000 on any write to DIV, regardless of the data; the counter does not increment in that cycle.
REQ-012 SHALL select the TIMA tap bit from TAC[1:0]: 00 selects rDivCnt[9], 01 selects [3], 10 selects [5], 11 selects [7].
REQ-013 SHALL form the tick signal as TAC[2] AND the tap bit, registered each cycle.
REQ-014 SHALL increment TIMA on the falling edge of the tick signal (previous value 1, current value 0).
REQ-015 Falling edges caused by a DIV write, by clearing TAC[2], or by a TAC[1:0] change SHALL also increment TIMA (DMG-compatible glitch).
REQ-016 SHALL handle TIMA overflow (increment from FF) as follows: TIMA loads TMA in the same edge, and oTimerIrq is high for exactly the next cycle.
REQ-017 SHALL let a CPU write to TIMA in the same cycle as an increment take precedence: TIMA takes iData, with no reload and no IRQ.
REQ-018 SHALL, when TMA is written in the same cycle as an overflow reload, load the new iData value into TIMA.
REQ-019 SHALL return on read: DIV = rDivCnt[15:8]; TIMA; TMA; TAC = {5'b11111, TAC[2:0]}.
REQ-020 SHALL drive oData = 8'h00 and oSelected = 0 when iAddr is outside the 4-byte window.
REQ-021 SHALL store only iData[2:0] on a TAC write.
REQ-022 SHALL ignore iWe when oSelected is 0.
REQ-023 SHALL have no read side effects.

Reset
REQ-024 While iReset is high, rDivCnt SHALL be 0000, TIMA 00, TMA 00, TAC 0, the tick register 0 and oTimerIrq 0.
REQ-025 Since oData is combinational, with iAddr = P_BASE+3 during reset it SHALL read F8.
REQ-026 Asserting iReset mid-count or mid-overflow SHALL abort immediately, with no IRQ pulse after release.
REQ-027 The first rDivCnt increment SHALL occur on the first rising edge after iReset is deasserted.

Verification
REQ-028 After reset, iAddr = P_BASE with no writes -> DIV reads 00 for cycles 1-255 and 01 at cycle 256; DIV reads 00 again after 65536 cycles.
REQ-029 Write DIV, then TAC = 05, TIMA = 00 -> TIMA increments every 16 clocks; reads 04 at 64 clocks after the DIV write (+/-1 cycle, per REQ-014 edge timing).
REQ-030 Write TMA = F0, TIMA = FE, TAC = 05 after a DIV write -> exactly one oTimerIrq pulse on the second increment; TIMA then reads F0 and continues F1 after 16 more clocks.
REQ-031 TAC = 05, wait until rDivCnt[3] = 1, then write DIV -> TIMA increments by 1 at once (REQ-015); with TAC = 01 the same DIV write does not increment TIMA.
REQ-032 Overflow cycle coincident with a TIMA write of 42 -> TIMA = 42 and no IRQ; the same cycle with a TMA write of 7A instead -> TIMA = 7A and one IRQ.
REQ-033 Write FF to TAC -> reads FF and the stored value is 7; read FF00 or FF08 -> oData 00, oSelected 0; a write to FF08 does not change any register.
